// File: rtl/exec_ctrl.sv
// Execute-stage sequencer: accepts one instruction, drives the ALU, writes back y and flags.
// Optional feature macro: EXEC_TRAP_EN (illegal op traps with sticky err instead of retiring as NOP).
module exec_ctrl #(
    parameter int WIDTH_WORD = 8,
    parameter int NREGS      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [8:0]            instr,
    input  logic                  ld_en,
    input  logic [1:0]            ld_sel,
    input  logic [WIDTH_WORD-1:0] ld_data,
    input  logic [1:0]            rd_sel,
    output logic [WIDTH_WORD-1:0] rd_data,
    output logic                  alu_active,
    output logic [2:0]            alu_op,
    output logic [WIDTH_WORD-1:0] alu_a,
    output logic [WIDTH_WORD-1:0] alu_b,
    input  logic [WIDTH_WORD-1:0] alu_y,
    input  logic                  alu_carry,
    output logic                  carry_flag,
    output logic                  zero_flag,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             rd_q, rd_d;
    logic [WIDTH_WORD-1:0]  regs_q [NREGS];
    logic [WIDTH_WORD-1:0]  regs_d [NREGS];
    logic [2:0]             op_q, op_d;
    logic [WIDTH_WORD-1:0]  a_q, a_d, b_q, b_d;
    logic                   active_q, active_d;
    logic                   carry_q, carry_d, zero_q, zero_d;
    logic                   done_q, done_d, err_q, err_d;
    logic                   accept, illegal;

`ifdef EXEC_TRAP_EN
    assign instr_ready = (state_q == IDLE) && !err_q;
`else
    assign instr_ready = (state_q == IDLE);
`endif

    assign accept  = instr_valid && instr_ready;
    // The op register holds the in-flight op through EXEC and WB.
    assign illegal = (op_q[2:1] == 2'b11);

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        regs_d   = regs_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        active_d = active_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
`ifdef EXEC_TRAP_EN
        err_d    = err_q;
`else
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ld_en) regs_d[ld_sel] = ld_data;
                // Operands come from regs_d so a same-edge load is seen by this instruction.
                if (accept) begin
                    rd_d     = instr[5:4];
                    op_d     = instr[8:6];
                    a_d      = regs_d[instr[3:2]];
                    b_d      = regs_d[instr[1:0]];
                    active_d = 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: state_d = WB;
            WB: begin
                state_d  = IDLE;
                active_d = 1'b0;
                if (!illegal) begin
                    regs_d[rd_q] = alu_y;
                    carry_d      = alu_carry;
                    zero_d       = (alu_y == '0);
                    done_d       = 1'b1;
                end else begin
                    err_d  = 1'b1;
`ifndef EXEC_TRAP_EN
                    done_d = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_q     <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            active_q <= 1'b0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            regs_q   <= regs_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            active_q <= active_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign rd_data    = regs_q[rd_sel];
    assign alu_active = active_q;
    assign alu_op     = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed testbench for exec_ctrl with a behavioural ALU model on the alu_* ports.
module tb_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, instr_valid, instr_ready, ld_en, alu_active, alu_carry;
    logic       carry_flag, zero_flag, done, err;
    logic [8:0] instr;
    logic [1:0] ld_sel, rd_sel;
    logic [2:0] alu_op;
    logic [7:0] ld_data, rd_data, alu_a, alu_b, alu_y;
    int         n_cmp = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    exec_ctrl #(.WIDTH_WORD(8), .NREGS(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
        .rd_sel(rd_sel), .rd_data(rd_data), .alu_active(alu_active), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_carry(alu_carry),
        .carry_flag(carry_flag), .zero_flag(zero_flag), .done(done), .err(err)
    );

    // ALU model; illegal ops produce a nonzero result with carry set so stray writes are visible.
    always_comb begin
        alu_y     = 8'h55;
        alu_carry = 1'b1;
        case (alu_op)
            3'b000: {alu_carry, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001: {alu_carry, alu_y} = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010: begin alu_y = alu_a & alu_b; alu_carry = 1'b0; end
            3'b011: begin alu_y = alu_a | alu_b; alu_carry = 1'b0; end
            3'b100: begin alu_y = ~alu_a;        alu_carry = 1'b0; end
            3'b101: begin alu_y = alu_a;         alu_carry = 1'b0; end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] sel, input logic [7:0] data);
        ld_en = 1'b1; ld_sel = sel; ld_data = data;
        tick();
        ld_en = 1'b0;
    endtask

    function automatic logic [7:0] peek(input logic [1:0] sel);
        rd_sel = sel;
        return dut.rd_data;
    endfunction

    // Offers ins and counts edges until done is seen (accept edge counts as 1); -1 on timeout.
    task automatic run_instr(input logic [8:0] ins, output int lat);
        instr_valid = 1'b1; instr = ins;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            instr_valid = 1'b0;
            if (done) begin lat = i; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; ld_en = 1'b0; ld_sel = '0; ld_data = '0; rd_sel = '0;
        tick(); tick();
        rst_n = 1'b1;
        n_cmp++; if ({instr_ready, alu_active, done, err, carry_flag, zero_flag} !== 6'b100000) begin
            n_fail++; $display("FAIL reset_ctrl got %b exp 100000", {instr_ready, alu_active, done, err, carry_flag, zero_flag}); end
        n_cmp++; if ({alu_op, alu_a, alu_b} !== 19'h0) begin
            n_fail++; $display("FAIL reset_alu got %h exp 0", {alu_op, alu_a, alu_b}); end
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s); #1;
            n_cmp++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_r%0d got %h exp 00", s, rd_data); end
        end
    endtask

    task automatic test_add();
        load(2'd1, 8'd5);
        load(2'd2, 8'd3);
        instr_valid = 1'b1; instr = {3'b000, 2'd0, 2'd1, 2'd2};
        tick();
        instr_valid = 1'b0;
        n_cmp++; if ({instr_ready, alu_active, done, alu_op, alu_a, alu_b} !== {1'b0, 1'b1, 1'b0, 3'b000, 8'd5, 8'd3}) begin
            n_fail++; $display("FAIL add_exec got %h exp %h", {instr_ready, alu_active, done, alu_op, alu_a, alu_b}, {1'b0, 1'b1, 1'b0, 3'b000, 8'd5, 8'd3}); end
        tick();
        n_cmp++; if ({alu_active, done} !== 2'b10) begin n_fail++; $display("FAIL add_wb got %b exp 10", {alu_active, done}); end
        tick();
        n_cmp++; if ({done, instr_ready, alu_active} !== 3'b110) begin
            n_fail++; $display("FAIL add_done got %b exp 110", {done, instr_ready, alu_active}); end
        rd_sel = 2'd0; #1;
        n_cmp++; if (rd_data !== 8'd8) begin n_fail++; $display("FAIL add_r0 got %h exp 08", rd_data); end
        n_cmp++; if ({carry_flag, zero_flag} !== 2'b00) begin n_fail++; $display("FAIL add_flags got %b exp 00", {carry_flag, zero_flag}); end
        n_cmp++; if (alu_op !== 3'b000 || alu_a !== 8'd5) begin n_fail++; $display("FAIL add_hold got %h/%h exp 0/05", alu_op, alu_a); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_pulse got %b exp 0", done); end
    endtask

    task automatic test_sub();
        int lat;
        run_instr({3'b001, 2'd3, 2'd2, 2'd1}, lat);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL sub_lat got %0d exp 3", lat); end
        rd_sel = 2'd3; #1;
        n_cmp++; if (rd_data !== 8'hFE) begin n_fail++; $display("FAIL sub_r3 got %h exp fe", rd_data); end
        n_cmp++; if ({carry_flag, zero_flag} !== 2'b10) begin n_fail++; $display("FAIL sub_flags got %b exp 10", {carry_flag, zero_flag}); end
    endtask

    task automatic test_back_to_back();
        int lat;
        tick();
        load(2'd1, 8'hA5);
        run_instr({3'b010, 2'd0, 2'd1, 2'd1}, lat);
        n_cmp++; if (lat !== 3 || instr_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first got lat %0d ready %b exp 3 1", lat, instr_ready); end
        run_instr({3'b100, 2'd2, 2'd0, 2'd0}, lat);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL b2b_second_lat got %0d exp 3", lat); end
        rd_sel = 2'd0; #1;
        n_cmp++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL b2b_r0 got %h exp a5", rd_data); end
        rd_sel = 2'd2; #1;
        n_cmp++; if (rd_data !== 8'h5A) begin n_fail++; $display("FAIL b2b_r2 got %h exp 5a", rd_data); end
        n_cmp++; if ({carry_flag, zero_flag} !== 2'b00) begin n_fail++; $display("FAIL b2b_flags got %b exp 00", {carry_flag, zero_flag}); end
    endtask

    task automatic test_load_collision();
        tick();
        ld_en = 1'b1; ld_sel = 2'd1; ld_data = 8'd7;
        instr_valid = 1'b1; instr = {3'b101, 2'd0, 2'd1, 2'd0};
        tick();
        ld_en = 1'b0; instr_valid = 1'b0;
        n_cmp++; if (alu_a !== 8'd7) begin n_fail++; $display("FAIL coll_alu_a got %h exp 07", alu_a); end
        tick(); tick();
        rd_sel = 2'd0; #1;
        n_cmp++; if (rd_data !== 8'd7) begin n_fail++; $display("FAIL coll_r0 got %h exp 07", rd_data); end
        // Load offered during EXEC must be dropped.
        tick();
        instr_valid = 1'b1; instr = {3'b000, 2'd3, 2'd0, 2'd1};
        tick();
        instr_valid = 1'b0;
        ld_en = 1'b1; ld_sel = 2'd2; ld_data = 8'h99;
        tick();
        ld_en = 1'b0;
        tick();
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL exec_ld_done got %b exp 1", done); end
        rd_sel = 2'd2; #1;
        n_cmp++; if (rd_data !== 8'h5A) begin n_fail++; $display("FAIL exec_ld_r2 got %h exp 5a", rd_data); end
        rd_sel = 2'd3; #1;
        n_cmp++; if (rd_data !== 8'd14) begin n_fail++; $display("FAIL exec_ld_r3 got %h exp 0e", rd_data); end
    endtask

    task automatic test_flags();
        int lat;
        tick();
        load(2'd1, 8'hFF);
        load(2'd2, 8'h01);
        run_instr({3'b000, 2'd3, 2'd1, 2'd2}, lat);
        rd_sel = 2'd3; #1;
        n_cmp++; if ({lat == 3, rd_data, carry_flag, zero_flag} !== {1'b1, 8'h00, 2'b11}) begin
            n_fail++; $display("FAIL add_ovf got lat %0d r3 %h c %b z %b exp 3 00 1 1", lat, rd_data, carry_flag, zero_flag); end
        run_instr({3'b001, 2'd0, 2'd1, 2'd1}, lat);
        rd_sel = 2'd0; #1;
        n_cmp++; if ({lat == 3, rd_data, carry_flag, zero_flag} !== {1'b1, 8'h00, 2'b01}) begin
            n_fail++; $display("FAIL sub_zero got lat %0d r0 %h c %b z %b exp 3 00 0 1", lat, rd_data, carry_flag, zero_flag); end
    endtask

    task automatic test_illegal();
        tick();
        instr_valid = 1'b1; instr = {3'b111, 2'd0, 2'd1, 2'd2};
        tick();
        instr_valid = 1'b0;
        tick(); tick();
`ifdef EXEC_TRAP_EN
        n_cmp++; if ({done, err, instr_ready} !== 3'b010) begin
            n_fail++; $display("FAIL trap_e2 got %b exp 010", {done, err, instr_ready}); end
        instr_valid = 1'b1; instr = {3'b000, 2'd0, 2'd1, 2'd2};
        tick(); tick(); tick(); tick();
        instr_valid = 1'b0;
        n_cmp++; if ({done, err, instr_ready, alu_active} !== 4'b0100) begin
            n_fail++; $display("FAIL trap_sticky got %b exp 0100", {done, err, instr_ready, alu_active}); end
`else
        n_cmp++; if ({done, err, instr_ready} !== 3'b111) begin
            n_fail++; $display("FAIL nop_e2 got %b exp 111", {done, err, instr_ready}); end
        tick();
        n_cmp++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL nop_pulse got %b exp 00", {done, err}); end
`endif
        rd_sel = 2'd0; #1;
        n_cmp++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL illegal_r0 got %h exp 00", rd_data); end
        n_cmp++; if ({carry_flag, zero_flag} !== 2'b01) begin n_fail++; $display("FAIL illegal_flags got %b exp 01", {carry_flag, zero_flag}); end
    endtask

    task automatic test_reset_in_wb();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        load(2'd1, 8'd5);
        load(2'd2, 8'd3);
        instr_valid = 1'b1; instr = {3'b000, 2'd0, 2'd1, 2'd2};
        tick();
        instr_valid = 1'b0;
        tick();
        n_cmp++; if (alu_active !== 1'b1) begin n_fail++; $display("FAIL rstwb_active got %b exp 1", alu_active); end
        rst_n = 1'b0;
        tick();
        n_cmp++; if ({instr_ready, alu_active, done, err, carry_flag, zero_flag} !== 6'b100000) begin
            n_fail++; $display("FAIL rstwb_ctrl got %b exp 100000", {instr_ready, alu_active, done, err, carry_flag, zero_flag}); end
        n_cmp++; if ({alu_op, alu_a, alu_b} !== 19'h0) begin n_fail++; $display("FAIL rstwb_alu got %h exp 0", {alu_op, alu_a, alu_b}); end
        rd_sel = 2'd0; #1;
        n_cmp++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rstwb_r0 got %h exp 00", rd_data); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if ({done, instr_ready} !== 2'b01) begin n_fail++; $display("FAIL rstwb_after got %b exp 01", {done, instr_ready}); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_load_collision();
        test_flags();
        test_illegal();
        test_reset_in_wb();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Execute-stage sequencer that sits directly upstream of the `alu` block and consumes its result. It accepts one decoded instruction at a time over a valid/ready handshake, reads two operands from its 4-entry register file, drives the ALU's `active`/`op`/`a`/`b` inputs, then writes `y` back to the destination register and latches the carry and zero flags. It also provides an external register load port and a debug read port, so the register file can be seeded and observed.

## Interface
Parameters (`WIDTH_WORD` and the 3-bit ALU op width come from `const.v`):
- `NREGS`, 4: register count; fixed, select fields are 2 bits.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous active-low reset; one clock, synchronous reset, active-low.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  block can accept an instruction.
- `instr`  in  9  bits [8:6] op, [5:4] rd, [3:2] ra, [1:0] rb.
- `ld_en`  in  1  external register write strobe.
- `ld_sel`  in  2  register written by `ld_en`.
- `ld_data`  in  WIDTH_WORD  value written by `ld_en`.
- `rd_sel`  in  2  debug read select.
- `rd_data`  out  WIDTH_WORD  combinational `reg[rd_sel]`.
- `alu_active`  out  1  to alu `active`.
- `alu_op`  out  3  to alu `op`.
- `alu_a`, `alu_b`  out  WIDTH_WORD  to alu `a`, `b`.
- `alu_y`  in  WIDTH_WORD  from alu `y`.
- `alu_carry`  in  1  from alu `carry`.
- `carry_flag`, `zero_flag`  out  1  flags from last completed instruction.
- `done`  out  1  one-cycle pulse, instruction retired.
- `err`  out  1  illegal-op indicator (see Configuration).

## Operation
- States: IDLE, EXEC, WB.
- IDLE: `instr_ready`=1 (unless trapped). On `instr_valid`&&`instr_ready`, latch `instr` and go to EXEC.
- EXEC: register `alu_op`=op, `alu_a`=reg[ra], `alu_b`=reg[rb], and set `alu_active`=1. Go to WB.
- WB: hold the ALU inputs and `alu_active`=1. At the end of WB, write `reg[rd]`←`alu_y`, `carry_flag`←`alu_carry`, `zero_flag`←(`alu_y`==0), then go to IDLE.
- Legal ops: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT, 101 MV. Ops 110/111 are illegal: no register or flag write.
- Outside EXEC/WB, `alu_active`=0, and `alu_op`/`alu_a`/`alu_b` hold their last values.
- `ld_en` is honoured only in IDLE; it is ignored in EXEC and WB. If a load and an accept occur on the same edge, the load is written first, so EXEC reads the new value.
- rd==ra or rd==rb is legal; operands are read in EXEC, before the writeback.

## Timing
- Accept at edge E0 → EXEC cycle → WB cycle → writeback at edge E2. `done`=1 in the cycle after E2, and `instr_ready`=1 in that same cycle.
- Throughput: one instruction per 3 cycles. Back-to-back accept at E2+1 sees the updated register.
- Reset values: state IDLE, all regs 0, `alu_active` 0, `alu_op`/`alu_a`/`alu_b` 0, `carry_flag` 0, `zero_flag` 0, `done` 0, `err` 0. `instr_ready` is 1 in the first cycle after reset.
- Reset asserted in EXEC or WB: abort, no writeback, and no `done`.
- The ALU contributes zero cycles: `alu_y`/`alu_carry` are sampled only at the end of WB, after the inputs have been stable for two cycles.

## Configuration
- `EXEC_TRAP_EN` defined: an illegal op sets `err` sticky at E2. `done` stays 0, and `instr_ready` stays 0 until `rst_n` is asserted.
- `EXEC_TRAP_EN` undefined: an illegal op retires as a NOP, with `done` pulsing and flags unchanged. `err` pulses for one cycle alongside `done`.

## Test plan
- Load r1=5, r2=3, then ADD rd=0 ra=1 rb=2 → `rd_data`(sel 0)=8, carry 0, zero 0, `done` exactly 3 cycles after accept.
- SUB rd=3 ra=2 rb=1 (3−5) → r3=2^W−2, carry_flag=1.
- Load r1=A5h pattern, then AND r0,r1,r1 followed immediately by NOT r2,r0 → r2=~A5h pattern, second accept on `done` cycle.
- `ld_en` r1=7 on the same edge as accept of MV r0,r1 → r0=7; `ld_en` during EXEC → r unchanged.
- Op 111: with `EXEC_TRAP_EN`, `err`=1 sticky and `instr_ready`=0 until reset; without it, `done`=1, regs and flags unchanged.
- `rst_n` low during WB of ADD → no writeback, all outputs at reset values next cycle.
